// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
// Optional parity framing is enabled by defining PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1
`ifdef PISO_PARITY_EN
    ,
    StParity = 2'd2
`endif
  } piso_state_e;

  // Bits per frame: data bits, plus one parity bit when enabled.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter holds the frame length with one code of headroom.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// The master side presents words; the slave side (the transmitter) shifts them out.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid,
        input  load_ready, dout, dout_valid, busy, done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, dout, dout_valid, busy, done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with gapless back-to-back framing.
// Define PISO_PARITY_EN to append an even-parity bit after each data word.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic       clk,
    input logic       rst,
    piso_tx_if.slave  bus
);

    localparam int unsigned CntW     = cnt_width(WIDTH);
    localparam int unsigned FrameLen = frame_len(WIDTH);

    piso_state_e       state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [CntW-1:0]   cnt_q;
    logic              dout_q;
    logic              dout_valid_q;
    logic              done_q;
`ifdef PISO_PARITY_EN
    logic              par_q;
`endif
    logic              accept;

    // Ready in idle and during the final bit of a frame, so the next word joins gaplessly.
    assign bus.load_ready = (state_q == StIdle) || (cnt_q == CntW'(1));
    assign accept         = bus.load_valid && bus.load_ready;

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = dout_valid_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else if (accept) begin
            // shift_q keeps the bit currently on dout at its outgoing end.
            state_q      <= StShift;
            shift_q      <= bus.din;
            cnt_q        <= CntW'(FrameLen);
            dout_q       <= MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
            dout_valid_q <= 1'b1;
            done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= ^bus.din;
`endif
        end else begin
            case (state_q)
                StShift: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q      <= StIdle;
                        shift_q      <= '0;
                        cnt_q        <= '0;
                        dout_q       <= 1'b0;
                        dout_valid_q <= 1'b0;
                        done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
                    end else if (cnt_q == CntW'(2)) begin
                        state_q      <= StParity;
                        shift_q      <= '0;
                        cnt_q        <= CntW'(1);
                        dout_q       <= par_q;
                        done_q       <= 1'b1;
`endif
                    end else begin
                        shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                        dout_q  <= MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
                        cnt_q   <= cnt_q - CntW'(1);
                        done_q  <= (cnt_q == CntW'(2));
                    end
                end
`ifdef PISO_PARITY_EN
                StParity: begin
                    state_q      <= StIdle;
                    cnt_q        <= '0;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    cnt_q        <= '0;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB/LSB order, back-to-back, ignored loads, async reset.
// Expected streams include the parity bit when PISO_PARITY_EN is defined.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int F = 5;
`else
    localparam int F = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(4)) bus_a ();
    piso_tx_if #(.WIDTH(4)) bus_b ();

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_a));
    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic test_reset();
        bus_a.din = 4'b0000; bus_a.load_valid = 1'b0;
        bus_b.din = 4'b0000; bus_b.load_valid = 1'b0;
        rst = 1'b1;
        #2;
        vectors++;
        if ({bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done});
        end
        vectors++;
        if (bus_a.load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", bus_a.load_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [4:0] exp = (F == 5) ? 5'b10111 : 5'b01011;
        bus_a.din = 4'b1011; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        for (int i = 0; i < F; i++) begin
            vectors++;
            if ({bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done, bus_a.load_ready}
                !== {exp[F-1-i], 1'b1, 1'b1, (i == F-1), (i == F-1)}) begin
                miscompares++;
                $display("FAIL msb_bit%0d: got d/v/b/dn/rdy=%b want %b", i,
                         {bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done,
                          bus_a.load_ready},
                         {exp[F-1-i], 1'b1, 1'b1, (i == F-1), (i == F-1)});
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus_a.dout, bus_a.dout_valid, bus_a.done, bus_a.load_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL msb_after: got d/v/dn/rdy=%b want 0001",
                     {bus_a.dout, bus_a.dout_valid, bus_a.done, bus_a.load_ready});
        end
    endtask

    task automatic test_lsb_first();
        logic [4:0] exp = (F == 5) ? 5'b11011 : 5'b01101;
        bus_b.din = 4'b1011; bus_b.load_valid = 1'b1;
        @(negedge clk);
        bus_b.load_valid = 1'b0;
        for (int i = 0; i < F; i++) begin
            vectors++;
            if ({bus_b.dout, bus_b.dout_valid, bus_b.done} !== {exp[F-1-i], 1'b1, (i == F-1)}) begin
                miscompares++;
                $display("FAIL lsb_bit%0d: got d/v/dn=%b want %b", i,
                         {bus_b.dout, bus_b.dout_valid, bus_b.done},
                         {exp[F-1-i], 1'b1, (i == F-1)});
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus_b.dout_valid, bus_b.load_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL lsb_after: got v/rdy=%b want 01", {bus_b.dout_valid, bus_b.load_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp = (F == 5) ? 10'b1011101100 : 10'b0010110110;
        bus_a.din = 4'b1011; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            vectors++;
            if ({bus_a.dout, bus_a.dout_valid, bus_a.done}
                !== {exp[2*F-1-i], 1'b1, (i == F-1) || (i == 2*F-1)}) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: got d/v/dn=%b want %b", i,
                         {bus_a.dout, bus_a.dout_valid, bus_a.done},
                         {exp[2*F-1-i], 1'b1, (i == F-1) || (i == 2*F-1)});
            end
            if (i == F - 1) begin
                bus_a.din = 4'b0110; bus_a.load_valid = 1'b1;
            end
            @(negedge clk);
            bus_a.load_valid = 1'b0;
        end
        vectors++;
        if (bus_a.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after: got valid %b want 0", bus_a.dout_valid);
        end
    endtask

    task automatic test_ignored_load();
        logic [4:0] exp = (F == 5) ? 5'b11110 : 5'b01111;
        bus_a.din = 4'b1111; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.din = 4'b0000;
        for (int i = 0; i < F; i++) begin
            if (i == 2) bus_a.load_valid = 1'b0;
            if (i < 2) begin
                vectors++;
                if (bus_a.load_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_ready%0d: got %b want 0", i, bus_a.load_ready);
                end
            end
            vectors++;
            if ({bus_a.dout, bus_a.dout_valid} !== {exp[F-1-i], 1'b1}) begin
                miscompares++;
                $display("FAIL hold_bit%0d: got d/v=%b want %b", i,
                         {bus_a.dout, bus_a.dout_valid}, {exp[F-1-i], 1'b1});
            end
            @(negedge clk);
        end
        vectors++;
        if (bus_a.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_after: got valid %b want 0", bus_a.dout_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] exp = (F == 5) ? 5'b00011 : 5'b00001;
        bus_a.din = 4'b1011; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({bus_a.dout, bus_a.dout_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_third_bit: got d/v=%b want 11", {bus_a.dout, bus_a.dout_valid});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done, bus_a.load_ready}
            !== 5'b00001) begin
            miscompares++;
            $display("FAIL rst_mid_frame: got d/v/b/dn/rdy=%b want 00001",
                     {bus_a.dout, bus_a.dout_valid, bus_a.busy, bus_a.done, bus_a.load_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus_a.dout_valid, bus_a.load_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_release: got v/rdy=%b want 01", {bus_a.dout_valid, bus_a.load_ready});
        end
        bus_a.din = 4'b0001; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        for (int i = 0; i < F; i++) begin
            vectors++;
            if ({bus_a.dout, bus_a.dout_valid, bus_a.done} !== {exp[F-1-i], 1'b1, (i == F-1)}) begin
                miscompares++;
                $display("FAIL fresh_bit%0d: got d/v/dn=%b want %b", i,
                         {bus_a.dout, bus_a.dout_valid, bus_a.done},
                         {exp[F-1-i], 1'b1, (i == F-1)});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_parity();
        logic [4:0] exp = (F == 5) ? 5'b10010 : 5'b01001;
        bus_a.din = 4'b1001; bus_a.load_valid = 1'b1;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        for (int i = 0; i < F; i++) begin
            vectors++;
            if ({bus_a.dout, bus_a.dout_valid, bus_a.done} !== {exp[F-1-i], 1'b1, (i == F-1)}) begin
                miscompares++;
                $display("FAIL par_bit%0d: got d/v/dn=%b want %b", i,
                         {bus_a.dout, bus_a.dout_valid, bus_a.done},
                         {exp[F-1-i], 1'b1, (i == F-1)});
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus_a.dout_valid, bus_a.load_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL par_after: got v/rdy=%b want 01", {bus_a.dout_valid, bus_a.load_ready});
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        @(negedge clk);
        test_lsb_first();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_ignored_load();
        @(negedge clk);
        test_async_reset();
        @(negedge clk);
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
